// File: rtl/alu_seq.sv
// alu_seq
// Accumulator-based command sequencer that feeds a 16-bit combinational ALU.
// One command is taken at a time over a valid/ready handshake. The sequencer
// either loads a value straight into the accumulator, or it registers the ALU
// operands and control. For an ALU command it then captures the ALU result
// and carry/borrow one cycle later. Each command returns one response over a
// second valid/ready handshake.
//
// Optional feature macro: ALU_SEQ_STATS_EN
//   When defined, this adds the output op_count. op_count is a wrapping count
//   of completed commands (loads and ALU operations), and rst clears it.
//
// Ports:
//   clk          in   sole clock, rising edge
//   rst          in   synchronous, active-high reset
//   cmd_valid    in   command present
//   cmd_ready    out  sequencer idle and able to accept a command
//   cmd_op       in   [1:0] ALU control code, forwarded unchanged
//   cmd_load     in   1 = load cmd_operand into acc, bypassing the ALU
//   cmd_operand  in   [15:0] B operand or load value
//   alu_control  out  [1:0] registered ALU control
//   alu_a        out  [15:0] registered ALU A (accumulator snapshot)
//   alu_b        out  [15:0] registered ALU B
//   alu_result   in   [15:0] ALU combinational result
//   alu_cb       in   ALU carry (add) / borrow (subtract)
//   acc          out  [15:0] accumulator
//   flag_cb      out  last captured carry/borrow
//   flag_z       out  accumulator is zero after the last command
//   rsp_valid    out  response available
//   rsp_ready    in   consumer accepts the response
//   rsp_data     out  [15:0] response data (the accumulator)
//   op_count     out  [15:0] completed-command count (ALU_SEQ_STATS_EN only)

module alu_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic        cmd_load,
  input  logic [15:0] cmd_operand,
  output logic [1:0]  alu_control,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [15:0] alu_result,
  input  logic        alu_cb,
  output logic [15:0] acc,
  output logic        flag_cb,
  output logic        flag_z,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [15:0] op_count
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   accept;

  // State register. Reset drops any in-flight command, so no response is
  // produced for that command.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs. cmd_ready is only high in IDLE. For
  // this reason, a response consumed in RESP cannot overlap a new acceptance:
  // cmd_ready rises on the following cycle.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept    = 1'b1;
          state_nxt = cmd_load ? RESP : EXEC;
        end
      end
      EXEC: begin
        state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath registers. The ALU operand registers change only when an ALU
  // command is accepted. The ALU output is therefore stable for the whole
  // EXEC cycle, which is when it gets captured. A load leaves flag_cb alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= 16'h0000;
      flag_cb     <= 1'b0;
      flag_z      <= 1'b1;
      alu_control <= 2'b00;
      alu_a       <= 16'h0000;
      alu_b       <= 16'h0000;
    end else begin
      if (accept) begin
        if (cmd_load) begin
          acc    <= cmd_operand;
          flag_z <= (cmd_operand == 16'h0000);
        end else begin
          alu_a       <= acc;
          alu_b       <= cmd_operand;
          alu_control <= cmd_op;
        end
      end
      if (state == EXEC) begin
        acc     <= alu_result;
        flag_cb <= alu_cb;
        flag_z  <= (alu_result == 16'h0000);
      end
    end
  end

  assign rsp_data = acc;

`ifdef ALU_SEQ_STATS_EN
  // A command completes either as a load at acceptance or as an ALU op in
  // EXEC. These two events never fall in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count <= 16'h0000;
    end else if ((accept && cmd_load) || (state == EXEC)) begin
      op_count <= op_count + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq
// Directed testbench for alu_seq. A small combinational ALU model sits
// downstream of the sequencer. Each scenario task drives stimulus and
// compares outputs against hand-computed values. Inputs are driven on the
// falling edge, and outputs are sampled there as well.

module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic        cmd_load;
  logic [15:0] cmd_operand;
  logic [1:0]  alu_control;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_result;
  logic        alu_cb;
  logic [15:0] acc;
  logic        flag_cb;
  logic        flag_z;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
`ifdef ALU_SEQ_STATS_EN
  logic [15:0] op_count;
`endif

  int checks = 0;
  int passes = 0;

  alu_seq dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_load    (cmd_load),
    .cmd_operand (cmd_operand),
    .alu_control (alu_control),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_result  (alu_result),
    .alu_cb      (alu_cb),
    .acc         (acc),
    .flag_cb     (flag_cb),
    .flag_z      (flag_z),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data)
`ifdef ALU_SEQ_STATS_EN
    ,
    .op_count    (op_count)
`endif
  );

  always #5 clk = ~clk;

  // Downstream ALU model. Code 10 is add with carry out, and code 11 is
  // subtract with borrow. The other codes give AND/OR with no carry, so that
  // forwarding of those codes can be observed.
  always_comb begin
    alu_result = 16'h0000;
    alu_cb     = 1'b0;
    case (alu_control)
      2'b10: {alu_cb, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
      2'b11: begin
        alu_result = alu_a - alu_b;
        alu_cb     = (alu_a < alu_b);
      end
      2'b00: alu_result = alu_a & alu_b;
      default: alu_result = alu_a | alu_b;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Presents one command for a single edge, starting from a falling edge.
  task automatic issue(input logic load, input logic [1:0] op, input logic [15:0] val);
    cmd_valid   = 1'b1;
    cmd_load    = load;
    cmd_op      = op;
    cmd_operand = val;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (acc !== 16'h0000) $display("[TB] FAIL reset_acc got %h want 0000", acc); else passes++;
    checks++; if (flag_z !== 1'b1) $display("[TB] FAIL reset_z got %b want 1", flag_z); else passes++;
    checks++; if (flag_cb !== 1'b0) $display("[TB] FAIL reset_cb got %b want 0", flag_cb); else passes++;
    checks++; if (rsp_valid !== 1'b0) $display("[TB] FAIL reset_rsp_valid got %b want 0", rsp_valid); else passes++;
    checks++; if ({alu_control, alu_a, alu_b} !== 34'h0) $display("[TB] FAIL reset_alu_regs got %h want 0", {alu_control, alu_a, alu_b}); else passes++;
    rst = 1'b0;
    tick();
    checks++; if (cmd_ready !== 1'b1) $display("[TB] FAIL reset_cmd_ready got %b want 1", cmd_ready); else passes++;
  endtask

  task automatic test_load_sub();
    issue(1'b1, 2'b00, 16'h0005);
    checks++; if (rsp_valid !== 1'b1) $display("[TB] FAIL load_rsp_valid got %b want 1", rsp_valid); else passes++;
    checks++; if (rsp_data !== 16'h0005) $display("[TB] FAIL load_rsp_data got %h want 0005", rsp_data); else passes++;
    checks++; if (flag_z !== 1'b0) $display("[TB] FAIL load_z got %b want 0", flag_z); else passes++;
    tick();
    checks++; if (cmd_ready !== 1'b1) $display("[TB] FAIL load_done_ready got %b want 1", cmd_ready); else passes++;
    issue(1'b0, 2'b11, 16'h0007);
    checks++; if (alu_a !== 16'h0005) $display("[TB] FAIL sub_alu_a got %h want 0005", alu_a); else passes++;
    checks++; if (alu_b !== 16'h0007) $display("[TB] FAIL sub_alu_b got %h want 0007", alu_b); else passes++;
    checks++; if (alu_control !== 2'b11) $display("[TB] FAIL sub_alu_control got %b want 11", alu_control); else passes++;
    checks++; if ({rsp_valid, cmd_ready} !== 2'b00) $display("[TB] FAIL sub_exec_handshake got %b want 00", {rsp_valid, cmd_ready}); else passes++;
    tick();
    checks++; if (rsp_valid !== 1'b1) $display("[TB] FAIL sub_rsp_valid got %b want 1", rsp_valid); else passes++;
    checks++; if (rsp_data !== 16'hFFFE) $display("[TB] FAIL sub_rsp_data got %h want FFFE", rsp_data); else passes++;
    checks++; if ({flag_cb, flag_z} !== 2'b10) $display("[TB] FAIL sub_flags got %b want 10", {flag_cb, flag_z}); else passes++;
    tick();
    checks++; if ({rsp_valid, cmd_ready} !== 2'b01) $display("[TB] FAIL sub_consumed got %b want 01", {rsp_valid, cmd_ready}); else passes++;
  endtask

  task automatic test_add_wrap();
    issue(1'b1, 2'b00, 16'hFFFF);
    checks++; if ({flag_cb, flag_z} !== 2'b10) $display("[TB] FAIL load_keeps_cb got %b want 10", {flag_cb, flag_z}); else passes++;
    tick();
    issue(1'b0, 2'b10, 16'h0001);
    tick();
    checks++; if (rsp_data !== 16'h0000) $display("[TB] FAIL add_wrap_data got %h want 0000", rsp_data); else passes++;
    checks++; if ({flag_cb, flag_z} !== 2'b11) $display("[TB] FAIL add_wrap_flags got %b want 11", {flag_cb, flag_z}); else passes++;
    tick();
  endtask

  task automatic test_op_forward();
    issue(1'b1, 2'b00, 16'h00F0);
    tick();
    issue(1'b0, 2'b00, 16'h0FF0);
    checks++; if (alu_control !== 2'b00) $display("[TB] FAIL fwd_control got %b want 00", alu_control); else passes++;
    tick();
    checks++; if (acc !== 16'h00F0) $display("[TB] FAIL fwd_acc got %h want 00F0", acc); else passes++;
    checks++; if ({flag_cb, flag_z} !== 2'b00) $display("[TB] FAIL fwd_flags got %b want 00", {flag_cb, flag_z}); else passes++;
    tick();
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    issue(1'b1, 2'b00, 16'h1234);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        cmd_valid   = 1'b1;
        cmd_load    = 1'b1;
        cmd_operand = 16'hBEEF;
      end
      checks++; if ({rsp_valid, cmd_ready, rsp_data} !== {2'b10, 16'h1234}) $display("[TB] FAIL bp_hold_%0d got %b/%b/%h want 1/0/1234", i, rsp_valid, cmd_ready, rsp_data); else passes++;
      tick();
      cmd_valid = 1'b0;
    end
    checks++; if (acc !== 16'h1234) $display("[TB] FAIL bp_acc got %h want 1234", acc); else passes++;
    rsp_ready   = 1'b1;
    cmd_valid   = 1'b1;
    cmd_load    = 1'b1;
    cmd_operand = 16'h0042;
    tick();
    checks++; if ({rsp_valid, cmd_ready, acc} !== {2'b01, 16'h1234}) $display("[TB] FAIL bp_consume got %b/%b/%h want 0/1/1234", rsp_valid, cmd_ready, acc); else passes++;
    tick();
    cmd_valid = 1'b0;
    checks++; if ({rsp_valid, acc} !== {1'b1, 16'h0042}) $display("[TB] FAIL bp_next_cmd got %b/%h want 1/0042", rsp_valid, acc); else passes++;
    tick();
  endtask

  task automatic test_reset_mid();
    issue(1'b1, 2'b00, 16'h0003);
    tick();
    issue(1'b0, 2'b10, 16'h0004);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({rsp_valid, acc, alu_a, alu_b} !== 49'h0) $display("[TB] FAIL rstmid_state got %b/%h/%h/%h want 0", rsp_valid, acc, alu_a, alu_b); else passes++;
    tick();
    checks++; if ({rsp_valid, cmd_ready, acc} !== {2'b01, 16'h0000}) $display("[TB] FAIL rstmid_after got %b/%b/%h want 0/1/0000", rsp_valid, cmd_ready, acc); else passes++;
    issue(1'b0, 2'b10, 16'h0009);
    tick();
    checks++; if ({rsp_valid, rsp_data, flag_cb} !== {1'b1, 16'h0009, 1'b0}) $display("[TB] FAIL rstmid_next got %b/%h/%b want 1/0009/0", rsp_valid, rsp_data, flag_cb); else passes++;
    tick();
  endtask

`ifdef ALU_SEQ_STATS_EN
  task automatic test_stats();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (op_count !== 16'h0000) $display("[TB] FAIL stats_reset got %h want 0000", op_count); else passes++;
    issue(1'b1, 2'b00, 16'h0001);
    tick();
    issue(1'b0, 2'b10, 16'h0002);
    tick();
    tick();
    issue(1'b0, 2'b11, 16'h0001);
    tick();
    tick();
    checks++; if (op_count !== 16'h0003) $display("[TB] FAIL stats_count got %h want 0003", op_count); else passes++;
  endtask
`endif

  initial begin
    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_load    = 1'b0;
    cmd_op      = 2'b00;
    cmd_operand = 16'h0000;
    rsp_ready   = 1'b1;
    @(negedge clk);
    test_reset();
    test_load_sub();
    test_add_wrap();
    test_op_forward();
    test_backpressure();
    test_reset_mid();
`ifdef ALU_SEQ_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
